// File: rtl/bpsk_encoder.sv
`default_nettype none
// ============================================================================
// Module      : bpsk_encoder
// Description : Turns one AXI-Stream squitter into a BPSK baseband burst
//               (preamble, NRZ payload, zero guard gap) as packed I/Q samples.
// Revision    : 1.0 - initial release
// ============================================================================
module bpsk_encoder #(
    parameter int SQUITTER_LENGTH        = 128,
    parameter int PAYLOAD_BITS           = 112,
    parameter int PREAMBLE_BITS          = 16,
    parameter int SAMPLES_PER_BIT        = 8,
    parameter int GAP_SAMPLES            = 16,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_areset,
    input  logic                                  s00_axis_tvalid,
    input  logic [SQUITTER_LENGTH-1:0]            s00_axis_tdata,
    input  logic                                  s00_axis_tlast,
    output logic                                  s00_axis_tready,
    output logic                                  m00_axis_tvalid,
    input  logic                                  m00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
    output logic                                  m00_axis_tlast,
    input  logic [PREAMBLE_BITS-1:0]              preamble_pattern,
    input  logic [15:0]                           amplitude
);

    localparam logic [1:0] c_st_idle     = 2'd0;
    localparam logic [1:0] c_st_preamble = 2'd1;
    localparam logic [1:0] c_st_payload  = 2'd2;
    localparam logic [1:0] c_st_gap      = 2'd3;

    localparam int c_max_bits = (PREAMBLE_BITS > PAYLOAD_BITS) ? PREAMBLE_BITS : PAYLOAD_BITS;
    localparam int c_bit_w    = (c_max_bits > 1) ? $clog2(c_max_bits) : 1;
    localparam int c_smp_w    = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
    localparam int c_gap_w    = (GAP_SAMPLES > 1) ? $clog2(GAP_SAMPLES) : 1;
    localparam int c_gap_max  = (GAP_SAMPLES > 0) ? GAP_SAMPLES - 1 : 0;

    localparam logic [c_bit_w-1:0] c_pre_last = c_bit_w'(PREAMBLE_BITS - 1);
    localparam logic [c_bit_w-1:0] c_pay_last = c_bit_w'(PAYLOAD_BITS - 1);
    localparam logic [c_bit_w-1:0] c_bit_one  = c_bit_w'(1);
    localparam logic [c_smp_w-1:0] c_smp_last = c_smp_w'(SAMPLES_PER_BIT - 1);
    localparam logic [c_smp_w-1:0] c_smp_one  = c_smp_w'(1);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(c_gap_max);
    localparam logic [c_gap_w-1:0] c_gap_one  = c_gap_w'(1);

    // Burst position and latched burst data
    logic [1:0]               r_state;
    logic [c_bit_w-1:0]       r_bit_cnt;
    logic [c_smp_w-1:0]       r_smp_cnt;
    logic [c_gap_w-1:0]       r_gap_cnt;
    logic [PREAMBLE_BITS-1:0] r_pre_sh;
    logic [PAYLOAD_BITS-1:0]  r_pay_sh;
    logic [15:0]              r_amp;

    // Output registers
    logic                     r_s_ready;
    logic                     r_tvalid;
    logic                     r_tlast;
    logic [15:0]              r_i;

    logic                     w_accept;
    logic                     w_handshake;
    logic                     w_step;
    logic                     w_smp_wrap;
    logic [15:0]              w_amp_clamped;

    logic [1:0]               w_nxt_state;
    logic [c_bit_w-1:0]       w_nxt_bit;
    logic [c_smp_w-1:0]       w_nxt_smp;
    logic [c_gap_w-1:0]       w_nxt_gap;
    logic [PREAMBLE_BITS-1:0] w_nxt_pre;
    logic [PAYLOAD_BITS-1:0]  w_nxt_pay;
    logic [15:0]              w_nxt_amp;
    logic                     w_nxt_bit_val;
    logic [15:0]              w_nxt_i;
    logic                     w_nxt_last;

    logic                     w_unused;

    assign w_unused      = ^{s00_axis_tlast, s00_axis_tdata};
    assign w_accept      = (r_state == c_st_idle) && r_s_ready && s00_axis_tvalid;
    assign w_handshake   = r_tvalid && m00_axis_tready;
    assign w_step        = w_accept || w_handshake;
    assign w_smp_wrap    = (r_smp_cnt == c_smp_last);
    assign w_amp_clamped = amplitude[15] ? 16'h7FFF : amplitude;

    // Position of the sample that will be presented after this step. The
    // current bit of each field is always the MSB of its shift register.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_bit   = r_bit_cnt;
        w_nxt_smp   = r_smp_cnt;
        w_nxt_gap   = r_gap_cnt;
        w_nxt_pre   = r_pre_sh;
        w_nxt_pay   = r_pay_sh;
        w_nxt_amp   = r_amp;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_nxt_state = c_st_preamble;
                    w_nxt_bit   = '0;
                    w_nxt_smp   = '0;
                    w_nxt_gap   = '0;
                    w_nxt_pre   = preamble_pattern;
                    w_nxt_pay   = s00_axis_tdata[PAYLOAD_BITS-1:0];
                    w_nxt_amp   = w_amp_clamped;
                end
            end
            c_st_preamble: begin
                if (w_smp_wrap) begin
                    w_nxt_smp = '0;
                    w_nxt_pre = r_pre_sh << 1;
                    if (r_bit_cnt == c_pre_last) begin
                        w_nxt_state = c_st_payload;
                        w_nxt_bit   = '0;
                    end else begin
                        w_nxt_bit = r_bit_cnt + c_bit_one;
                    end
                end else begin
                    w_nxt_smp = r_smp_cnt + c_smp_one;
                end
            end
            c_st_payload: begin
                if (w_smp_wrap) begin
                    w_nxt_smp = '0;
                    w_nxt_pay = r_pay_sh << 1;
                    if (r_bit_cnt == c_pay_last) begin
                        w_nxt_bit = '0;
                        w_nxt_gap = '0;
                        if (GAP_SAMPLES > 0) begin
                            w_nxt_state = c_st_gap;
                        end else begin
                            w_nxt_state = c_st_idle;
                        end
                    end else begin
                        w_nxt_bit = r_bit_cnt + c_bit_one;
                    end
                end else begin
                    w_nxt_smp = r_smp_cnt + c_smp_one;
                end
            end
            default: begin
                if (r_gap_cnt == c_gap_last) begin
                    w_nxt_state = c_st_idle;
                    w_nxt_gap   = '0;
                end else begin
                    w_nxt_gap = r_gap_cnt + c_gap_one;
                end
            end
        endcase
    end

    always_comb begin
        w_nxt_bit_val = (w_nxt_state == c_st_preamble) ? w_nxt_pre[PREAMBLE_BITS-1]
                                                       : w_nxt_pay[PAYLOAD_BITS-1];
        w_nxt_i = 16'h0000;
        if ((w_nxt_state == c_st_preamble) || (w_nxt_state == c_st_payload)) begin
            w_nxt_i = w_nxt_bit_val ? w_nxt_amp : (16'h0000 - w_nxt_amp);
        end
        w_nxt_last = 1'b0;
        if ((w_nxt_state == c_st_gap) && (w_nxt_gap == c_gap_last)) begin
            w_nxt_last = 1'b1;
        end
        if ((GAP_SAMPLES == 0) && (w_nxt_state == c_st_payload) &&
            (w_nxt_bit == c_pay_last) && (w_nxt_smp == c_smp_last)) begin
            w_nxt_last = 1'b1;
        end
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            r_state   <= c_st_idle;
            r_bit_cnt <= '0;
            r_smp_cnt <= '0;
            r_gap_cnt <= '0;
            r_pre_sh  <= '0;
            r_pay_sh  <= '0;
            r_amp     <= 16'h0000;
            r_s_ready <= 1'b0;
            r_tvalid  <= 1'b0;
            r_tlast   <= 1'b0;
            r_i       <= 16'h0000;
        end else begin
            r_s_ready <= ((w_step ? w_nxt_state : r_state) == c_st_idle);
            if (w_step) begin
                r_state   <= w_nxt_state;
                r_bit_cnt <= w_nxt_bit;
                r_smp_cnt <= w_nxt_smp;
                r_gap_cnt <= w_nxt_gap;
                r_pre_sh  <= w_nxt_pre;
                r_pay_sh  <= w_nxt_pay;
                r_amp     <= w_nxt_amp;
                r_tvalid  <= (w_nxt_state != c_st_idle);
                r_tlast   <= w_nxt_last;
                r_i       <= w_nxt_i;
            end
        end
    end

    assign s00_axis_tready = r_s_ready;
    assign m00_axis_tvalid = r_tvalid;
    assign m00_axis_tlast  = r_tlast;
    assign m00_axis_tdata  = {{(C_M00_AXIS_TDATA_WIDTH-16){1'b0}}, r_i};
    assign m00_axis_tstrb  = {(C_M00_AXIS_TDATA_WIDTH/8){1'b1}};

endmodule
`default_nettype wire

// File: tb/tb_bpsk_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bpsk_encoder
// Description : Scoreboard bench for bpsk_encoder, plus a GAP_SAMPLES=0 instance
//               whose output is decoded back to the payload.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bpsk_encoder;

    localparam int PRE = 4;
    localparam int PAY = 8;
    localparam int SPB = 2;
    localparam int GAP = 2;
    localparam int SQL = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            s_tvalid = 1'b0;
    logic [SQL-1:0]  s_tdata = '0;
    logic            s_tlast = 1'b0;
    logic            s_tready;
    logic            m_tvalid;
    logic            m_tready = 1'b1;
    logic [31:0]     m_tdata;
    logic [3:0]      m_tstrb;
    logic            m_tlast;
    logic [PRE-1:0]  pre = '0;
    logic [15:0]     amp = '0;

    logic            s2_tvalid = 1'b0;
    logic [SQL-1:0]  s2_tdata = '0;
    logic            s2_tready;
    logic            m2_tvalid;
    logic            m2_tready = 1'b1;
    logic [31:0]     m2_tdata;
    logic [3:0]      m2_tstrb;
    logic            m2_tlast;

    always #5 clk = ~clk;

    bpsk_encoder #(
        .SQUITTER_LENGTH(SQL), .PAYLOAD_BITS(PAY), .PREAMBLE_BITS(PRE),
        .SAMPLES_PER_BIT(SPB), .GAP_SAMPLES(GAP), .C_M00_AXIS_TDATA_WIDTH(32)
    ) u_dut (
        .s00_axis_aclk(clk), .s00_axis_areset(rst),
        .s00_axis_tvalid(s_tvalid), .s00_axis_tdata(s_tdata),
        .s00_axis_tlast(s_tlast), .s00_axis_tready(s_tready),
        .m00_axis_tvalid(m_tvalid), .m00_axis_tready(m_tready),
        .m00_axis_tdata(m_tdata), .m00_axis_tstrb(m_tstrb),
        .m00_axis_tlast(m_tlast),
        .preamble_pattern(pre), .amplitude(amp)
    );

    bpsk_encoder #(
        .SQUITTER_LENGTH(SQL), .PAYLOAD_BITS(PAY), .PREAMBLE_BITS(PRE),
        .SAMPLES_PER_BIT(SPB), .GAP_SAMPLES(0), .C_M00_AXIS_TDATA_WIDTH(32)
    ) u_dut_nogap (
        .s00_axis_aclk(clk), .s00_axis_areset(rst),
        .s00_axis_tvalid(s2_tvalid), .s00_axis_tdata(s2_tdata),
        .s00_axis_tlast(1'b0), .s00_axis_tready(s2_tready),
        .m00_axis_tvalid(m2_tvalid), .m00_axis_tready(m2_tready),
        .m00_axis_tdata(m2_tdata), .m00_axis_tstrb(m2_tstrb),
        .m00_axis_tlast(m2_tlast),
        .preamble_pattern(pre), .amplitude(amp)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_pop    = 0;
    bit          mon_en   = 1'b0;
    bit          stall_prev = 1'b0;
    bit          in_burst = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    exp_t        mon_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
        end
    endtask

    // Reference burst: preamble then payload bits MSB first, each held SPB samples
    task automatic push_burst(input logic [7:0] payload, input logic [3:0] pre_b,
                              input logic [15:0] a_in);
        int          a;
        logic [11:0] bits;
        exp_t        e;
        a    = (int'(a_in) > 32767) ? 32767 : int'(a_in);
        bits = {pre_b, payload};
        for (int b = 11; b >= 0; b--) begin
            for (int s = 0; s < SPB; s++) begin
                e.data = {16'h0000, 16'(bits[b] ? a : -a)};
                e.last = 1'b0;
                exp_q.push_back(e);
            end
        end
        for (int g = 0; g < GAP; g++) begin
            e.data = 32'h0;
            e.last = (g == GAP - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input logic [SQL-1:0] d, input logic [3:0] p,
                        input logic [15:0] a, input bit hold);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        s_tdata  = d;
        pre      = p;
        amp      = a;
        s_tvalid = 1'b1;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!hold) s_tvalid = 1'b0;
        chk("accept", 32'(acc), 32'd1);
        chk("first_sample_valid", 32'(m_tvalid), 32'd1);
        chk("s_tready_low_after_accept", 32'(s_tready), 32'd0);
    endtask

    task automatic drain(input bit rnd, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_tvalid) && n < budget) begin
            @(posedge clk);
            #1;
            m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        m_tready = 1'b1;
        chk("drain_in_budget", 32'(n < budget), 32'd1);
    endtask

    // Output monitor: scoreboard pop on handshake, stall stability, no bubbles
    always @(negedge clk) begin
        if (mon_en) begin
            if (stall_prev) begin
                chk("stall_tvalid_held", 32'(m_tvalid), 32'd1);
                chk("stall_tdata_stable", m_tdata, prev_data);
                chk("stall_tlast_stable", 32'(m_tlast), 32'(prev_last));
            end
            if (in_burst) chk("no_bubble", 32'(m_tvalid), 32'd1);
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_sample", 32'(m_tvalid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sample_tdata", m_tdata, mon_e.data);
                    chk("sample_tlast", 32'(m_tlast), 32'(mon_e.last));
                    n_pop++;
                    in_burst = !mon_e.last;
                end
            end
            stall_prev = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
        end else begin
            stall_prev = 1'b0;
            in_burst   = 1'b0;
        end
    end

    initial begin
        int      n;
        int      base;
        bit      seen_last;
        int      lb[0:63];
        int      idx;
        int      last_idx;
        int      sum;
        logic [7:0] rec;
        shortint v;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_tlast", 32'(m_tlast), 32'd0);
        chk("rst_tdata", m_tdata, 32'h0);
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("s_tready_after_reset", 32'(s_tready), 32'd1);
        chk("tstrb", 32'(m_tstrb), 32'hF);
        mon_en = 1'b1;

        // Basic burst
        push_burst(8'hA5, 4'b1010, 16'd1000);
        send(16'h00A5, 4'b1010, 16'd1000, 1'b0);
        drain(1'b0, 200);

        // Backpressure; upper squitter bits ignored; mid-burst input changes ignored
        push_burst(8'h5A, 4'b1001, 16'd1234);
        send(16'hFF5A, 4'b1001, 16'd1234, 1'b0);
        amp = 16'd7;
        pre = 4'b0000;
        drain(1'b1, 400);

        // Amplitude clamp
        push_burst(8'hC3, 4'b1110, 16'hFFFF);
        send(16'h00C3, 4'b1110, 16'hFFFF, 1'b0);
        drain(1'b0, 200);

        // Input blocking with a second squitter held valid
        push_burst(8'h96, 4'b1010, 16'd300);
        push_burst(8'h0F, 4'b0110, 16'd300);
        send(16'h0096, 4'b1010, 16'd300, 1'b1);
        s_tdata = 16'h000F;
        pre     = 4'b0110;
        n = 0;
        seen_last = 1'b0;
        while (!seen_last && n < 200) begin
            @(negedge clk);
            n++;
            if (m_tvalid) chk("blocked_s_tready", 32'(s_tready), 32'd0);
            if (m_tvalid && m_tlast && m_tready) seen_last = 1'b1;
        end
        chk("blocked_burst_end", 32'(seen_last), 32'd1);
        @(negedge clk);
        chk("idle_gap_s_tready", 32'(s_tready), 32'd1);
        chk("idle_gap_tvalid", 32'(m_tvalid), 32'd0);
        @(negedge clk);
        chk("second_first_sample", 32'(m_tvalid), 32'd1);
        s_tvalid = 1'b0;
        drain(1'b0, 200);

        // Reset while sample 10 is on the output
        push_burst(8'h33, 4'b1011, 16'd2000);
        base = n_pop;
        send(16'h0033, 4'b1011, 16'd2000, 1'b0);
        n = 0;
        while ((n_pop - base) < 9 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reached_sample10", 32'(n_pop - base), 32'd9);
        rst    = 1'b1;
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_tvalid", 32'(m_tvalid), 32'd0);
        chk("abort_tlast", 32'(m_tlast), 32'd0);
        chk("abort_tdata", m_tdata, 32'h0);
        chk("abort_s_tready", 32'(s_tready), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_abort_s_tready", 32'(s_tready), 32'd1);
        exp_q.delete();
        mon_en = 1'b1;
        push_burst(8'h6C, 4'b0101, 16'd2000);
        send(16'h006C, 4'b0101, 16'd2000, 1'b0);
        drain(1'b0, 200);

        // GAP_SAMPLES=0 instance looped into a sign decoder
        pre       = 4'b1100;
        amp       = 16'd500;
        s2_tdata  = 16'h003C;
        s2_tvalid = 1'b1;
        @(negedge clk);
        chk("lb_s_tready", 32'(s2_tready), 32'd1);
        @(posedge clk);
        #1;
        s2_tvalid = 1'b0;
        idx = 0;
        last_idx = -1;
        seen_last = 1'b0;
        n = 0;
        while (!seen_last && n < 100 && idx < 64) begin
            @(negedge clk);
            n++;
            if (m2_tvalid) begin
                v = m2_tdata[15:0];
                lb[idx] = int'(v);
                if (m2_tlast) begin
                    seen_last = 1'b1;
                    last_idx  = idx;
                end
                idx++;
            end
        end
        chk("lb_tlast_index", 32'(last_idx), 32'd23);
        chk("lb_sample_count", 32'(idx), 32'd24);
        rec = 8'h00;
        for (int b = 0; b < PAY; b++) begin
            sum = 0;
            for (int s = 0; s < SPB; s++) sum += lb[(PRE + b) * SPB + s];
            rec[7 - b] = (sum > 0);
        end
        chk("lb_payload", 32'(rec), 32'h3C);
        @(negedge clk);
        chk("lb_idle_after", 32'(m2_tvalid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
